// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div : multi-cycle signed/unsigned integer divider (restoring, 1 bit/cycle)
//
// Responder side of the execute-stage divide handshake. Operands are taken as
// magnitudes on the start edge, divided with a shift/subtract loop, then
// sign-corrected on the last iteration edge.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request/hold a division; 0 releases the result
//   annul_i       abort an in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//
// state  | meaning
// -------+-----------------------------------------------------------
// FREE   | idle, outputs zero, waiting for start_i
// BYZERO | divisor was zero, result of zero delivered next edge
// ON     | iterating, one quotient bit per edge
// END    | result valid, held until start_i drops
// ---------------------------------------------------------------------------
module div #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [1:0] S_FREE   = 2'd0;
   localparam logic [1:0] S_BYZERO = 2'd1;
   localparam logic [1:0] S_ON     = 2'd2;
   localparam logic [1:0] S_END    = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_dsr;
   logic              r_sign1;
   logic              r_sign2;
   logic              r_signed;

   logic [DATA_W-1:0] w_abs1;
   logic [DATA_W-1:0] w_abs2;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W:0]   w_diff;
   logic              w_qbit;
   logic [DATA_W-1:0] w_rem_nxt;
   logic [DATA_W-1:0] w_quo_nxt;
   logic [DATA_W-1:0] w_rem_fix;
   logic [DATA_W-1:0] w_quo_fix;

   assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

   // r_dvd shifts dividend bits out of its MSB while quotient bits enter at
   // its LSB, so after DATA_W iterations it holds the magnitude quotient.
   // The partial remainder is always below the divisor, so one extra bit
   // is enough for the shifted trial value.
   assign w_trial   = {r_rem, r_dvd[DATA_W-1]};
   assign w_diff    = w_trial - {1'b0, r_dsr};
   assign w_qbit    = ~w_diff[DATA_W];
   assign w_rem_nxt = w_qbit ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
   assign w_quo_nxt = {r_dvd[DATA_W-2:0], w_qbit};

   assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = (r_signed && r_sign1) ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_FREE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dsr    <= '0;
         r_sign1  <= 1'b0;
         r_sign2  <= 1'b0;
         r_signed <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (r_state)
            S_FREE: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_state <= S_BYZERO;
                  end else begin
                     r_state  <= S_ON;
                     r_sign1  <= opdata1_i[DATA_W-1];
                     r_sign2  <= opdata2_i[DATA_W-1];
                     r_signed <= signed_div_i;
                     r_rem    <= '0;
                     r_dvd    <= w_abs1;
                     r_dsr    <= w_abs2;
                     r_cnt    <= CNT_W'(DATA_W - 1);
                  end
               end
            end
            S_BYZERO: begin
               r_state  <= S_END;
               result_o <= '0;
               ready_o  <= 1'b1;
            end
            S_ON: begin
               if (annul_i) begin
                  r_state <= S_FREE;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_dvd <= w_quo_nxt;
                  // Final iteration and sign fix share one edge.
                  if (r_cnt == '0) begin
                     r_state  <= S_END;
                     result_o <= {w_rem_fix, w_quo_fix};
                     ready_o  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: begin
               if (!start_i) begin
                  r_state  <= S_FREE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int errors;

   div #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division semantics (truncating toward zero,
   // remainder takes the dividend's sign), results wrapped to 32 bits.
   function automatic logic [63:0] model(input logic sg, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Raise start, scramble operands while busy, wait for ready, check
   // latency and result. Leaves start_i high (DUT in END).
   task automatic start_and_wait(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
      int n;
      int explat;
      logic [63:0] exp;
      exp    = model(sg, a, b);
      explat = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = 1'($urandom);
      end while (!ready_o && n < 100);
      chk({tag, "_latency"}, 64'(n), 64'(explat));
      chk({tag, "_result"}, result_o, exp);
   endtask

   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      start_and_wait(sg, a, b, tag);
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, {63'd0, ready_o} ^ 64'd0 | (result_o ^ model(sg, a, b)) << 1,
          64'd1);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_release"}, {result_o[62:0], ready_o} | {63'd0, result_o[63]}, 64'd0);
   endtask

   initial begin
      int n;
      logic sg;
      logic [31:0] a, b;
      int unsigned sel;
      checks       = 0;
      errors       = 0;
      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      #23;
      chk("reset_ready", {63'd0, ready_o}, 64'd0);
      chk("reset_result", result_o, 64'd0);
      rst = 1'b1;

      do_div(1'b0, 32'd100, 32'd7, "u100_7");
      chk("u100_7_model", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      do_div(1'b1, 32'hFFFFFFF9, 32'd2, "s_m7_2");
      do_div(1'b1, 32'd7, 32'hFFFFFFFE, "s_7_m2");
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
      do_div(1'b0, 32'hFFFFFFFF, 32'd1, "u_max_1");
      do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, "u_big");
      do_div(1'b0, 32'd12345, 32'd0, "u_zero");
      do_div(1'b1, 32'h80000000, 32'd0, "s_zero");

      // annul at iteration 10
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'hDEADBEEF;
      opdata2_i    = 32'd5;
      start_i      = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready_o || result_o != 64'd0) n++;
      end
      chk("annul_quiet", 64'(n), 64'd0);
      do_div(1'b0, 32'd9, 32'd3, "u9_3");

      // async reset mid-ON
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_on", {result_o[62:0], ready_o} | {63'd0, result_o[63]}, 64'd0);
      start_i = 1'b0;
      #3;
      rst = 1'b1;
      // async reset mid-END: check before any clock edge
      start_and_wait(1'b0, 32'd100, 32'd7, "pre_rst_end");
      #2;
      rst = 1'b0;
      #1;
      chk("rst_end", {result_o[62:0], ready_o} | {63'd0, result_o[63]}, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_div(1'b0, 32'd100, 32'd7, "post_rst");

      // randomized traffic with corner operands mixed in
      repeat (150) begin
         sg  = 1'($urandom);
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = $urandom;
         case (sel)
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = $urandom_range(1, 16);
            4: b = 32'h80000000;
            5: a = $urandom_range(0, 100);
            default: ;
         endcase
         do_div(sg, a, b, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit signed/unsigned integer divider; the responder side of the execute stage's divide handshake.
- Execute stage drives operands, signedness and start. The divider runs a restoring shift-subtract loop, one quotient bit per cycle.
- Returns {remainder, quotient} with a ready flag. Execute stage writes HI = remainder, LO = quotient.
- Execute stage stalls the pipeline while ready is low.

Parameters:
- DATA_W, 32, operand width. Result is 2*DATA_W; iteration count = DATA_W. Only 32 is verified.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- signed_div_i  input  1  1 = signed divide, 0 = unsigned.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  1 = request/hold a division; 0 = release.
- annul_i  input  1  1 = abort the in-flight division (pipeline flush).
- result_o  output  2*DATA_W  [63:32] remainder, [31:0] quotient.
- ready_o  output  1  result_o valid.

Behaviour:
- States: FREE, BYZERO, ON, END. Reset state FREE; result_o = 0, ready_o = 0. Reset is effective immediately, including mid-operation; the in-flight result is discarded.
- FREE
  - start_i=1, annul_i=0, opdata2_i=0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. Latch original sign bits of both operands and signed_div_i. Load the working dividend with |opdata1_i| (two's complement if signed and bit31=1, otherwise as-is), divisor likewise; cnt=0.
  - Otherwise stay; ready_o=0, result_o=0.
- BYZERO: next edge -> END, result_o = 0, ready_o = 1.
- ON
  - annul_i=1 -> FREE; ready_o stays 0; result_o unchanged (0).
  - Else, while cnt<32: shift partial remainder left one bit, bringing in the next dividend MSB, and trial-subtract the divisor (33-bit compare).
    - Non-negative difference: remainder = difference, quotient bit = 1.
    - Negative difference: remainder unchanged, quotient bit = 0.
    - cnt++.
  - cnt==32: apply sign fix and register the outputs, then -> END.
    - Quotient negated if latched signed and sign1 XOR sign2.
    - Remainder negated if latched signed and sign1.
    - result_o = {rem, quo}, ready_o = 1.
  - start_i is ignored during ON; only annul_i aborts. Operand inputs are ignored after the FREE load.
- END
  - start_i=1: hold result_o and ready_o=1.
  - start_i=0: -> FREE; result_o=0 and ready_o=0 on that edge.
  - annul_i is ignored in END.
- Latency, counted from the edge that samples start_i in FREE:
  - Non-zero divisor: ready_o high after 33 edges (1 load + 32 iterations; finalize on edge 33, per ON rules above).
  - Zero divisor: ready_o high after 2 edges.
- Back-to-back: the requester must drop start_i for at least one cycle after ready_o; the next start is sampled in FREE.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0; no flag.
- Unsigned path never negates. Magnitudes are treated as 32-bit unsigned, so |0x80000000| = 0x80000000 is handled correctly.

Test Plan:
1. Unsigned 100/7, start held high -> ready_o rises exactly 33 cycles after start is sampled; result_o=0x00000002_0000000E. Drop start -> next cycle ready_o=0, result_o=0.
2. Signed cases:
   - 0xFFFFFFF9(-7)/2 -> result_o=0xFFFFFFFF_FFFFFFFD.
   - 7/0xFFFFFFFE(-2) -> 0x00000001_FFFFFFFD.
   - 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
3. Unsigned boundary cases:
   - 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
   - 0x80000000/0xFFFFFFFF unsigned -> 0x80000000_00000000.
4. Divide by zero (any dividend, either signedness) -> ready_o high 2 cycles after start; result_o=0.
5. annul_i pulsed at iteration 10 -> state FREE, ready_o never asserts. A following unsigned 9/3 completes with 0x00000000_00000003 at full latency.
6. rst driven low asynchronously mid-ON and mid-END -> ready_o and result_o go to 0 immediately without a clock edge. After release, 100/7 still yields the scenario-1 result.
